matrix_op_scheduler: RTL and testbench

Shares one elementwise matrix unit pair (4x4 add and subtract engines, 8-bit in, 16-bit out) among NUM_REQ requesters inside the NPU. It arbitrates round-robin, drives the operand mux select and the unit start strobes, and times completion with a latency counter. It strobes result capture and returns a valid/ready response to the granted requester. Operand and result datapath muxing sits outside this block; the scheduler carries control only.

---
 rtl/npu_pkg.sv | 27 ++
 rtl/matrix_op_scheduler_if.sv | 31 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/matrix_op_scheduler.sv | 139 +++++++++++++
 tb/tb_matrix_op_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: opcodes, scheduler states and matrix-unit geometry.
package npu_pkg;

    localparam int MAT_DIM   = 4;
    localparam int ELEM_W    = 8;
    localparam int RES_W     = 16;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSV2 = 2'b10,
        OP_RSV3 = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

    function automatic logic is_valid_op(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_op_scheduler_if.sv
// Request/response bundle between the requesters (master) and the scheduler (slave).
interface matrix_op_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   resp_ready;
    logic [NUM_REQ-1:0]   gnt;
    logic [SEL_W-1:0]     sel;
    logic                 add_start;
    logic                 sub_start;
    logic                 cap_en;
    logic [NUM_REQ-1:0]   resp_valid;
    logic                 resp_err;
    logic                 busy;
    logic [CNT_W-1:0]     issued_cnt;

    modport master (
        output req, req_op, resp_ready,
        input  gnt, sel, add_start, sub_start, cap_en, resp_valid, resp_err, busy, issued_cnt
    );

    modport slave (
        input  req, req_op, resp_ready,
        output gnt, sel, add_start, sub_start, cap_en, resp_valid, resp_err, busy, issued_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0] upper_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Prefer requests at or above the pointer; fall back to the full vector to wrap.
    always_comb begin
        upper_mask = '0;
        for (int j = 0; j < N; j++) begin
            if (IDX_W'(j) >= ptr) upper_mask[j] = 1'b1;
        end
        masked    = req & upper_mask;
        pool      = (|masked) ? masked : req;
        grant     = '0;
        grant_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (pool[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/matrix_op_scheduler.sv
// Control-only scheduler sharing the elementwise add/sub matrix units among requesters.
module matrix_op_scheduler
    import npu_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int UNIT_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_op_scheduler_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REQ);

    sched_state_t         state_q, state_n;
    logic [NUM_REQ-1:0]   gnt_q, gnt_n, rv_q, rv_n, arb_gnt;
    logic [SEL_W-1:0]     sel_q, sel_n, rr_q, rr_n, arb_idx;
    op_t                  op_q, op_n, pick_op;
    logic [LAT_CNT_W-1:0] lat_q, lat_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 add_q, add_n, sub_q, sub_n, cap_q, cap_n, err_q, err_n, busy_q;
    logic                 arb_any;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req),
        .ptr       (rr_q),
        .grant     (arb_gnt),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        pick_op = OP_ADD;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_idx == SEL_W'(j)) pick_op = op_t'(bus.req_op[2*j +: 2]);
        end
    end

    // Start strobes are decided on the grant edge so they appear registered in ISSUE.
    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        op_n    = op_q;
        lat_n   = lat_q;
        rv_n    = rv_q;
        err_n   = err_q;
        rr_n    = rr_q;
        cnt_n   = cnt_q;
        add_n   = 1'b0;
        sub_n   = 1'b0;
        cap_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_n   = arb_gnt;
                    sel_n   = arb_idx;
                    op_n    = pick_op;
                    add_n   = (pick_op == OP_ADD);
                    sub_n   = (pick_op == OP_SUB);
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (is_valid_op(op_q)) begin
                    lat_n   = LAT_CNT_W'(UNIT_LAT - 1);
                    state_n = ST_WAIT;
                end else begin
                    err_n   = 1'b1;
                    rv_n    = gnt_q;
                    state_n = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    cap_n   = 1'b1;
                    rv_n    = gnt_q;
                    state_n = ST_RESP;
                end else begin
                    lat_n = lat_q - LAT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (|(bus.resp_ready & gnt_q)) begin
                    gnt_n   = '0;
                    rv_n    = '0;
                    err_n   = 1'b0;
                    rr_n    = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
                    if (!err_q && (cnt_q != '1)) cnt_n = cnt_q + CNT_W'(1);
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            op_q    <= OP_ADD;
            lat_q   <= '0;
            rv_q    <= '0;
            err_q   <= 1'b0;
            rr_q    <= '0;
            cnt_q   <= '0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            cap_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            op_q    <= op_n;
            lat_q   <= lat_n;
            rv_q    <= rv_n;
            err_q   <= err_n;
            rr_q    <= rr_n;
            cnt_q   <= cnt_n;
            add_q   <= add_n;
            sub_q   <= sub_n;
            cap_q   <= cap_n;
            busy_q  <= (state_n != ST_IDLE);
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.add_start  = add_q;
    assign bus.sub_start  = sub_q;
    assign bus.cap_en     = cap_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = busy_q;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Bench for matrix_op_scheduler: a fast (UNIT_LAT=1, CNT_W=4) and a slow (UNIT_LAT=15) instance.
module tb_matrix_op_scheduler;

    localparam int N     = 4;
    localparam int LAT_F = 1;
    localparam int LAT_S = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matrix_op_scheduler_if #(.NUM_REQ(N), .CNT_W(4))  bus_f();
    matrix_op_scheduler_if #(.NUM_REQ(N), .CNT_W(16)) bus_s();

    matrix_op_scheduler #(.NUM_REQ(N), .UNIT_LAT(LAT_F), .CNT_W(4)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    matrix_op_scheduler #(.NUM_REQ(N), .UNIT_LAT(LAT_S), .CNT_W(16)) u_slow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    int check_cnt  = 0;
    int pass_cnt   = 0;
    int cyc        = 0;
    bit compare_on = 1'b0;

    // Timeline model: an operation is described by its age in cycles since the grant edge.
    bit         m_act [2];
    int         m_sel [2];
    logic [1:0] m_op  [2];
    int         m_age [2];
    int         m_ptr [2];
    int         m_cnt [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0; m_sel[k] = 0; m_op[k] = 2'b00;
            m_age[k] = 0;    m_ptr[k] = 0; m_cnt[k] = 0;
        end
    end

    function automatic int latOf(input int k);
        return (k == 0) ? LAT_F : LAT_S;
    endfunction

    function automatic int cntMax(input int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    function automatic int respStart(input int k);
        return m_op[k][1] ? 2 : latOf(k) + 2;
    endfunction

    function automatic int ohIdx(input logic [3:0] oh);
        for (int i = 0; i < N; i++) if (oh == (4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeoutFail(input string name);
        check_cnt++;
        $display("[TB] FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
    endtask

    task automatic applyStimulus(input int k, input logic [3:0] r, input logic [7:0] ops,
                                 input logic [3:0] rdy);
        if (k == 0) begin
            bus_f.req = r; bus_f.req_op = ops; bus_f.resp_ready = rdy;
        end else begin
            bus_s.req = r; bus_s.req_op = ops; bus_s.resp_ready = rdy;
        end
    endtask

    task automatic modelStep();
        logic [3:0] rq;
        logic [3:0] rd;
        logic [7:0] op;
        int         j;
        for (int k = 0; k < 2; k++) begin
            rq = (k == 0) ? bus_f.req        : bus_s.req;
            rd = (k == 0) ? bus_f.resp_ready : bus_s.resp_ready;
            op = (k == 0) ? bus_f.req_op     : bus_s.req_op;
            if (!rst_n) begin
                m_act[k] = 1'b0; m_ptr[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_age[k] = 0;
            end else if (!m_act[k]) begin
                for (int i = 0; i < N; i++) begin
                    j = (m_ptr[k] + i) % N;
                    if (!m_act[k] && ((rq >> j) & 4'b0001) != 4'b0000) begin
                        m_act[k] = 1'b1;
                        m_sel[k] = j;
                        m_op[k]  = 2'(op >> (2 * j));
                        m_age[k] = 1;
                    end
                end
            end else if (m_age[k] >= respStart(k) && ((rd >> m_sel[k]) & 4'b0001) != 4'b0000) begin
                m_act[k] = 1'b0;
                m_ptr[k] = (m_sel[k] + 1) % N;
                if (!m_op[k][1] && m_cnt[k] < cntMax(k)) m_cnt[k]++;
            end else begin
                m_age[k]++;
            end
        end
    endtask

    task automatic compareInst(input int k, input string nm, input logic [3:0] gnt,
                               input logic [1:0] sel, input logic add, input logic sub,
                               input logic cap, input logic [3:0] rv, input logic err,
                               input logic busy, input logic [15:0] ic);
        logic [3:0] eg, erv;
        logic       eadd, esub, ecap, eerr;
        int         a;
        a    = m_age[k];
        eg   = m_act[k] ? (4'b0001 << m_sel[k]) : 4'b0000;
        eadd = m_act[k] && a == 1 && m_op[k] == 2'b00;
        esub = m_act[k] && a == 1 && m_op[k] == 2'b01;
        ecap = m_act[k] && !m_op[k][1] && a == latOf(k) + 2;
        erv  = (m_act[k] && a >= respStart(k)) ? eg : 4'b0000;
        eerr = m_act[k] && m_op[k][1] && a >= 2;
        checkOutput({nm, ".gnt"},        32'(gnt),  32'(eg));
        checkOutput({nm, ".sel"},        32'(sel),  32'(m_sel[k]));
        checkOutput({nm, ".add_start"},  32'(add),  32'(eadd));
        checkOutput({nm, ".sub_start"},  32'(sub),  32'(esub));
        checkOutput({nm, ".cap_en"},     32'(cap),  32'(ecap));
        checkOutput({nm, ".resp_valid"}, 32'(rv),   32'(erv));
        checkOutput({nm, ".resp_err"},   32'(err),  32'(eerr));
        checkOutput({nm, ".busy"},       32'(busy), 32'(m_act[k]));
        checkOutput({nm, ".issued_cnt"}, 32'(ic),   32'(m_cnt[k]));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (compare_on) begin
            compareInst(0, "fast", bus_f.gnt, bus_f.sel, bus_f.add_start, bus_f.sub_start,
                        bus_f.cap_en, bus_f.resp_valid, bus_f.resp_err, bus_f.busy,
                        16'(bus_f.issued_cnt));
            compareInst(1, "slow", bus_s.gnt, bus_s.sel, bus_s.add_start, bus_s.sub_start,
                        bus_s.cap_en, bus_s.resp_valid, bus_s.resp_err, bus_s.busy,
                        bus_s.issued_cnt);
        end
    end

    task automatic doReset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic waitIdle(input int k, input int bound, input string name);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (((k == 0) ? bus_f.busy : bus_s.busy) == 1'b0) done = 1'b1;
        end
        if (!done) timeoutFail(name);
    endtask

    initial begin
        int  grants [5];
        int  n, adds, caps, starts, last_start;
        bit  done;

        rst_n = 1'b0;
        applyStimulus(0, 4'b0000, 8'h00, 4'b0000);
        applyStimulus(1, 4'b0000, 8'h00, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_on = 1'b1;
        checkOutput("reset.fast.gnt",  32'(bus_f.gnt), 32'h0);
        checkOutput("reset.fast.busy", 32'(bus_f.busy), 32'h0);
        checkOutput("reset.fast.cnt",  32'(bus_f.issued_cnt), 32'h0);
        checkOutput("reset.slow.busy", 32'(bus_s.busy), 32'h0);

        $display("[TB] single ADD");
        applyStimulus(0, 4'b0001, 8'h00, 4'b1111);
        @(negedge clk);
        checkOutput("add.c1.add_start", 32'(bus_f.add_start), 32'h1);
        checkOutput("add.c1.gnt",       32'(bus_f.gnt), 32'h1);
        applyStimulus(0, 4'b0000, 8'h00, 4'b1111);
        @(negedge clk);
        checkOutput("add.c2.add_start", 32'(bus_f.add_start), 32'h0);
        checkOutput("add.c2.resp_valid", 32'(bus_f.resp_valid), 32'h0);
        @(negedge clk);
        checkOutput("add.c3.cap_en",     32'(bus_f.cap_en), 32'h1);
        checkOutput("add.c3.resp_valid", 32'(bus_f.resp_valid), 32'h1);
        @(negedge clk);
        checkOutput("add.c4.busy",       32'(bus_f.busy), 32'h0);
        checkOutput("add.c4.issued_cnt", 32'(bus_f.issued_cnt), 32'h1);

        $display("[TB] round-robin SUB");
        doReset();
        applyStimulus(0, 4'b1111, 8'b0101_0101, 4'b1111);
        n = 0; adds = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            @(negedge clk);
            if (bus_f.add_start) adds++;
            if (bus_f.sub_start) begin
                grants[n] = ohIdx(bus_f.gnt);
                n++;
                if (n == 5) applyStimulus(0, 4'b0000, 8'h00, 4'b1111);
            end
        end
        if (n < 5) timeoutFail("rr.grants");
        waitIdle(0, 20, "rr.idle");
        checkOutput("rr.grant0", 32'(grants[0]), 32'd0);
        checkOutput("rr.grant1", 32'(grants[1]), 32'd1);
        checkOutput("rr.grant2", 32'(grants[2]), 32'd2);
        checkOutput("rr.grant3", 32'(grants[3]), 32'd3);
        checkOutput("rr.grant4", 32'(grants[4]), 32'd0);
        checkOutput("rr.add_starts", 32'(adds), 32'd0);

        $display("[TB] backpressure");
        doReset();
        applyStimulus(0, 4'b0100, 8'h00, 4'b0000);
        @(negedge clk);
        applyStimulus(0, 4'b0000, 8'h00, 4'b0000);
        caps = 0; starts = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus_f.cap_en) caps++;
            if (bus_f.resp_valid != 4'b0000) done = 1'b1;
        end
        if (!done) timeoutFail("bp.resp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp.hold.resp_valid", 32'(bus_f.resp_valid), 32'h4);
            if (bus_f.cap_en) caps++;
            if (bus_f.add_start || bus_f.sub_start) starts++;
        end
        checkOutput("bp.cap_pulses", 32'(caps), 32'd1);
        checkOutput("bp.starts", 32'(starts), 32'd0);
        applyStimulus(0, 4'b0000, 8'h00, 4'b0100);
        @(negedge clk);
        checkOutput("bp.done.resp_valid", 32'(bus_f.resp_valid), 32'h0);
        checkOutput("bp.done.issued_cnt", 32'(bus_f.issued_cnt), 32'h1);

        $display("[TB] reserved opcode");
        applyStimulus(0, 4'b0010, 8'b0000_1100, 4'b1111);
        @(negedge clk);
        checkOutput("rsv.c1.gnt", 32'(bus_f.gnt), 32'h2);
        checkOutput("rsv.c1.starts", 32'({bus_f.add_start, bus_f.sub_start}), 32'h0);
        applyStimulus(0, 4'b0000, 8'h00, 4'b1111);
        @(negedge clk);
        checkOutput("rsv.c2.resp_valid", 32'(bus_f.resp_valid), 32'h2);
        checkOutput("rsv.c2.resp_err",   32'(bus_f.resp_err), 32'h1);
        checkOutput("rsv.c2.cap_en",     32'(bus_f.cap_en), 32'h0);
        @(negedge clk);
        checkOutput("rsv.c3.resp_err",   32'(bus_f.resp_err), 32'h0);
        checkOutput("rsv.c3.issued_cnt", 32'(bus_f.issued_cnt), 32'h1);

        $display("[TB] reset mid-WAIT");
        doReset();
        applyStimulus(1, 4'b0001, 8'h00, 4'b1111);
        @(negedge clk);
        applyStimulus(1, 4'b0000, 8'h00, 4'b1111);
        waitIdle(1, 40, "rst.first_op");
        applyStimulus(1, 4'b0011, 8'h00, 4'b1111);
        @(negedge clk);
        checkOutput("rst.c1.gnt", 32'(bus_s.gnt), 32'h2);
        repeat (3) @(negedge clk);
        checkOutput("rst.c4.busy", 32'(bus_s.busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst.c5.gnt",        32'(bus_s.gnt), 32'h0);
        checkOutput("rst.c5.busy",       32'(bus_s.busy), 32'h0);
        checkOutput("rst.c5.resp_valid", 32'(bus_s.resp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst.c6.gnt",       32'(bus_s.gnt), 32'h1);
        checkOutput("rst.c6.add_start", 32'(bus_s.add_start), 32'h1);
        applyStimulus(1, 4'b0000, 8'h00, 4'b1111);
        waitIdle(1, 40, "rst.regrant_op");

        $display("[TB] latency spacing");
        applyStimulus(1, 4'b1000, 8'h00, 4'b1111);
        caps = 0; n = 0; last_start = 0;
        for (int i = 0; i < 200 && caps < 3; i++) begin
            @(negedge clk);
            if (bus_s.add_start) begin
                if (n > 0) checkOutput("lat.start_spacing", 32'(cyc - last_start), 32'd18);
                last_start = cyc;
                n++;
            end
            if (bus_s.cap_en) begin
                checkOutput("lat.start_to_cap", 32'(cyc - last_start), 32'd16);
                caps++;
                if (caps == 3) applyStimulus(1, 4'b0000, 8'h00, 4'b1111);
            end
        end
        if (caps < 3) timeoutFail("lat.caps");
        waitIdle(1, 20, "lat.idle");

        $display("[TB] saturation");
        doReset();
        applyStimulus(0, 4'b0001, 8'h00, 4'b1111);
        n = 0; last_start = 0;
        for (int i = 0; i < 200 && n < 20; i++) begin
            @(negedge clk);
            if (bus_f.add_start) begin
                if (n > 0) checkOutput("sat.start_spacing", 32'(cyc - last_start), 32'd4);
                last_start = cyc;
                n++;
                if (n == 20) applyStimulus(0, 4'b0000, 8'h00, 4'b1111);
            end
        end
        if (n < 20) timeoutFail("sat.starts");
        waitIdle(0, 20, "sat.idle");
        checkOutput("sat.issued_cnt", 32'(bus_f.issued_cnt), 32'd15);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
